bus_rr_arbiter: RTL and testbench

- Replaces fixed-priority master arbitration on the shared system bus (4 masters, 8 slaves).
- Grants bus ownership round-robin with an ownership-tenure limit, so the CPU instruction and data ports cannot starve the DMA and debug masters (M2/M3).
- Runs a slave-ready watchdog on the shared slave bus: a hung slave terminates the transfer with a forced ready plus an error flag.
- Sits between the master Req_/Grnt_ lines and the bus mux; its owner index drives the master-to-slave mux select.

---
 rtl/bus_rr_arbiter_pkg.sv | 32 +++
 rtl/bus_rr_arbiter_rr_pick.sv | 31 +++
 rtl/bus_rr_arbiter.sv | 149 ++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_rr_arbiter_pkg.sv
// Shared bus arbiter definitions: master count, owner index type,
// master indices, arbiter state encoding and active-low levels.
package bus_rr_arbiter_pkg;

    localparam int BUS_MASTER_CH = 4;
    localparam int BUS_OWNER_W   = 2;

    typedef logic [BUS_OWNER_W-1:0] busOwner_t;

    localparam busOwner_t BUS_MASTER_0 = 2'd0;
    localparam busOwner_t BUS_MASTER_1 = 2'd1;
    localparam busOwner_t BUS_MASTER_2 = 2'd2;
    localparam busOwner_t BUS_MASTER_3 = 2'd3;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arbState_t;

    function automatic logic [BUS_MASTER_CH-1:0] ownerOneHot(
        input busOwner_t idx
    );
        logic [BUS_MASTER_CH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational 4-way round-robin picker.
// Ports: req (active-high requests), last (previous winner) -> winner, anyReq.
module bus_rr_arbiter_rr_pick
    import bus_rr_arbiter_pkg::*;
(
    input  logic [BUS_MASTER_CH-1:0] req,
    input  logic [BUS_OWNER_W-1:0]   last,
    output logic [BUS_OWNER_W-1:0]   winner,
    output logic                     anyReq
);

    logic [BUS_OWNER_W-1:0] idx;
    logic                   found;

    // Scan last+1 .. last+4; last itself is checked only at the very end.
    always_comb begin
        winner = last;
        found  = 1'b0;
        idx    = last;
        for (int i = 1; i <= BUS_MASTER_CH; i++) begin
            idx = last + BUS_OWNER_W'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign anyReq = |req;

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with tenure limit and slave-ready watchdog.
// Ports: clk, reset_, m0..3Req_/m0..3Grnt_, sAs_, sRdy_, owner, ownerVld, toRdy_, busErr, errOwner.
module bus_rr_arbiter
    import bus_rr_arbiter_pkg::*;
#(
    parameter int TENURE_MAX = 16,
    parameter int WAIT_MAX   = 32,
    parameter int TEN_W      = 5,
    parameter int WAIT_W     = 6
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       m0Req_,
    input  logic       m1Req_,
    input  logic       m2Req_,
    input  logic       m3Req_,
    output logic       m0Grnt_,
    output logic       m1Grnt_,
    output logic       m2Grnt_,
    output logic       m3Grnt_,
    input  logic       sAs_,
    input  logic       sRdy_,
    output logic [1:0] owner,
    output logic       ownerVld,
    output logic       toRdy_,
    output logic       busErr,
    output logic [1:0] errOwner
);

    localparam logic [TEN_W-1:0]  TEN_MAX_C = TEN_W'(TENURE_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    logic [BUS_MASTER_CH-1:0] req;
    logic [BUS_MASTER_CH-1:0] grntQ, grntD;
    arbState_t                stateQ, stateD;
    busOwner_t                ownerQ, ownerD;
    busOwner_t                lastQ, lastD;
    logic [TEN_W-1:0]         tenQ, tenD;
    busOwner_t                pickW;
    logic                     pickAny;
    logic                     othersReq;
    logic                     handOff;

    logic [WAIT_W-1:0]        wdQ;
    logic                     toRdyQ;
    logic                     busErrQ;
    busOwner_t                errOwnerQ;
    logic                     hung;
    logic                     fire;

    assign req = ~{m3Req_, m2Req_, m1Req_, m0Req_};

    bus_rr_arbiter_rr_pick uPick (
        .req    (req),
        .last   (lastQ),
        .winner (pickW),
        .anyReq (pickAny)
    );

    assign othersReq = |(req & ~ownerOneHot(ownerQ));

    always_comb begin
        stateD  = stateQ;
        ownerD  = ownerQ;
        lastD   = lastQ;
        tenD    = tenQ;
        grntD   = grntQ;
        handOff = 1'b0;
        unique case (stateQ)
            ARB_IDLE: handOff = pickAny;
            ARB_OWNED: begin
                if (!req[ownerQ]) begin
                    handOff = pickAny;
                    if (!pickAny) begin
                        stateD = ARB_IDLE;
                        grntD  = {BUS_MASTER_CH{DISABLE_}};
                    end
                end else if (tenQ == TEN_MAX_C && othersReq
                             && sAs_ == DISABLE_) begin
                    // Tenure spent, others waiting, no open transfer.
                    handOff = 1'b1;
                end else if (tenQ != TEN_MAX_C) begin
                    tenD = tenQ + 1'b1;
                end
            end
            default: ;
        endcase
        if (handOff) begin
            stateD = ARB_OWNED;
            ownerD = pickW;
            lastD  = pickW;
            tenD   = '0;
            grntD  = ~ownerOneHot(pickW);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            stateQ <= ARB_IDLE;
            ownerQ <= BUS_MASTER_0;
            lastQ  <= BUS_MASTER_3;
            tenQ   <= '0;
            grntQ  <= {BUS_MASTER_CH{DISABLE_}};
        end else begin
            stateQ <= stateD;
            ownerQ <= ownerD;
            lastQ  <= lastD;
            tenQ   <= tenD;
            grntQ  <= grntD;
        end
    end

    // A slave asserting ready on the final count wins over the timeout.
    assign hung = (sAs_ == ENABLE_) && (sRdy_ == DISABLE_);
    assign fire = hung && (wdQ == WAIT_LAST);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wdQ       <= '0;
            toRdyQ    <= DISABLE_;
            busErrQ   <= 1'b0;
            errOwnerQ <= BUS_MASTER_0;
        end else begin
            toRdyQ <= fire ? ENABLE_ : DISABLE_;
            if (hung && !fire) begin
                wdQ <= wdQ + 1'b1;
            end else begin
                wdQ <= '0;
            end
            if (fire) begin
                busErrQ   <= 1'b1;
                errOwnerQ <= ownerQ;
            end else if (busErrQ && !req[errOwnerQ]) begin
                busErrQ <= 1'b0;
            end
        end
    end

    assign m0Grnt_  = grntQ[0];
    assign m1Grnt_  = grntQ[1];
    assign m2Grnt_  = grntQ[2];
    assign m3Grnt_  = grntQ[3];
    assign owner    = ownerQ;
    assign ownerVld = (stateQ == ARB_OWNED);
    assign toRdy_   = toRdyQ;
    assign busErr   = busErrQ;
    assign errOwner = errOwnerQ;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: cycle model feeds a scoreboard
// queue, plus directed checks on hand-off timing and watchdog behaviour.
module tb_bus_rr_arbiter;

    localparam int TEN  = 16;
    localparam int WAIT = 32;

    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic       m0Req_ = 1'b1, m1Req_ = 1'b1, m2Req_ = 1'b1, m3Req_ = 1'b1;
    logic       m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_;
    logic       sAs_ = 1'b1, sRdy_ = 1'b1;
    logic [1:0] owner;
    logic       ownerVld;
    logic       toRdy_;
    logic       busErr;
    logic [1:0] errOwner;

    always #5 clk = ~clk;

    bus_rr_arbiter #(
        .TENURE_MAX (TEN),
        .WAIT_MAX   (WAIT),
        .TEN_W      (5),
        .WAIT_W     (6)
    ) dut (
        .clk      (clk),
        .reset_   (reset_),
        .m0Req_   (m0Req_),
        .m1Req_   (m1Req_),
        .m2Req_   (m2Req_),
        .m3Req_   (m3Req_),
        .m0Grnt_  (m0Grnt_),
        .m1Grnt_  (m1Grnt_),
        .m2Grnt_  (m2Grnt_),
        .m3Grnt_  (m3Grnt_),
        .sAs_     (sAs_),
        .sRdy_    (sRdy_),
        .owner    (owner),
        .ownerVld (ownerVld),
        .toRdy_   (toRdy_),
        .busErr   (busErr),
        .errOwner (errOwner)
    );

    int nChecks = 0;
    int nPass   = 0;
    logic [10:0] expQ[$];

    logic       mVld;
    logic [1:0] mOwn, mLast, mErrOwn;
    int         mTen, mWd;
    logic       mToRdy_, mErr;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    function automatic logic [1:0] rrNext(input logic [3:0] r,
                                          input logic [1:0] from);
        logic [1:0] c;
        for (int k = 4; k >= 1; k--) begin
            c = from + 2'(k);
            if (r[c]) rrNext = c;
        end
    endfunction

    function automatic logic [10:0] expVec();
        logic [3:0] g;
        g = 4'hF;
        if (mVld) g[mOwn] = 1'b0;
        return {g, mOwn, mVld, mToRdy_, mErr, mErrOwn};
    endfunction

    function automatic logic [10:0] dutVec();
        return {m3Grnt_, m2Grnt_, m1Grnt_, m0Grnt_,
                owner, ownerVld, toRdy_, busErr, errOwner};
    endfunction

    task automatic modelReset();
        mVld = 1'b0; mOwn = 2'd0; mLast = 2'd3; mErrOwn = 2'd0;
        mTen = 0; mWd = 0; mToRdy_ = 1'b1; mErr = 1'b0;
    endtask

    task automatic modelEdge(input logic [3:0] r, input logic as_,
                             input logic rdy_);
        logic fire;
        logic [1:0] w;
        fire = 1'b0;
        if (!as_ && rdy_) begin
            mWd++;
            if (mWd >= WAIT) begin fire = 1'b1; mWd = 0; end
        end else begin
            mWd = 0;
        end
        if (fire) begin mErr = 1'b1; mErrOwn = mOwn; end
        else if (mErr && !r[mErrOwn]) mErr = 1'b0;
        mToRdy_ = ~fire;
        w = rrNext(r, mLast);
        if (!mVld || !r[mOwn]) begin
            if (r != 4'h0) begin
                mVld = 1'b1; mOwn = w; mLast = w; mTen = 0;
            end else begin
                mVld = 1'b0;
            end
        end else if (mTen == TEN && as_ && (r & ~(4'b0001 << mOwn)) != 4'h0) begin
            mOwn = w; mLast = w; mTen = 0;
        end else if (mTen < TEN) begin
            mTen++;
        end
    endtask

    task automatic step(input logic [3:0] r, input logic as_, input logic rdy_);
        @(negedge clk);
        m0Req_ = ~r[0]; m1Req_ = ~r[1]; m2Req_ = ~r[2]; m3Req_ = ~r[3];
        sAs_ = as_; sRdy_ = rdy_;
        modelEdge(r, as_, rdy_);
        expQ.push_back(expVec());
        @(posedge clk);
        #1;
        check("cycle", dutVec(), expQ.pop_front());
    endtask

    task automatic doReset();
        logic [10:0] rv;
        rv = {4'hF, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0};
        @(negedge clk);
        #2;
        reset_ = 1'b0;
        m0Req_ = 1'b1; m1Req_ = 1'b1; m2Req_ = 1'b1; m3Req_ = 1'b1;
        sAs_ = 1'b1; sRdy_ = 1'b1;
        #1;
        check("reset", dutVec(), rv);
        modelReset();
        expQ.delete();
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int held, prev, idle, cnt, pulses, pulseAt;
        bit done;
        int seq[$];
        int expOrd[5] = '{0, 1, 2, 3, 0};
        logic [3:0] r;
        logic as_;

        modelReset();
        doReset();

        // Simple grant and release
        step(4'b0001, 1'b1, 1'b1);
        check("t1 m0Grnt_", m0Grnt_, 0);
        check("t1 owner", owner, 0);
        repeat (3) step(4'b0001, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b1);
        check("t1 vld", ownerVld, 0);
        step(4'b0000, 1'b1, 1'b1);

        // Everyone requesting, each owner releases after 3 cycles
        doReset();
        held = 0; prev = -1; idle = 0;
        for (int n = 0; n < 20; n++) begin
            r = 4'hF;
            if (ownerVld && held == 3) r[owner] = 1'b0;
            step(r, 1'b1, 1'b1);
            if (ownerVld) begin
                if (int'(owner) != prev) begin
                    seq.push_back(int'(owner));
                    prev = int'(owner);
                    held = 1;
                end else begin
                    held++;
                end
            end else begin
                idle++;
            end
        end
        check("t2 idle", idle, 0);
        for (int i = 0; i < 5; i++)
            check($sformatf("t2 ord%0d", i), (seq.size() > i) ? seq[i] : 99, expOrd[i]);

        // Tenure-limited hand-off
        doReset();
        step(4'b0001, 1'b1, 1'b1);
        cnt = 0; done = 0;
        for (int n = 1; n <= 60 && !done; n++) begin
            step((n >= 3) ? 4'b0101 : 4'b0001, 1'b1, 1'b1);
            cnt++;
            if (ownerVld && owner == 2'd2) done = 1;
        end
        check("t3 hold", cnt, 17);
        check("t3 owner", owner, 2);
        step(4'b0000, 1'b1, 1'b1);

        // Hand-off deferred by an open transfer
        doReset();
        step(4'b0001, 1'b1, 1'b1);
        cnt = 0; done = 0;
        for (int n = 1; n <= 60 && !done; n++) begin
            as_ = !(n >= 10 && n <= 25);
            step((n >= 3) ? 4'b0101 : 4'b0001, as_, 1'b1);
            cnt++;
            if (ownerVld && owner == 2'd2) done = 1;
        end
        check("t4 hold", cnt, 26);
        check("t4 owner", owner, 2);

        // Watchdog fires on a hung slave
        doReset();
        step(4'b0010, 1'b1, 1'b1);
        pulses = 0; pulseAt = 0;
        for (int n = 1; n <= 40; n++) begin
            step(4'b0010, 1'b0, 1'b1);
            if (!toRdy_) begin pulses++; pulseAt = n; end
        end
        check("t5 pulses", pulses, 1);
        check("t5 pulseAt", pulseAt, WAIT);
        check("t5 busErr", busErr, 1);
        check("t5 errOwner", errOwner, 1);
        step(4'b0000, 1'b1, 1'b1);
        check("t5 clear", busErr, 0);

        // Slave ready on the final count beats the watchdog
        doReset();
        step(4'b0010, 1'b1, 1'b1);
        pulses = 0;
        for (int n = 1; n <= 31; n++) begin
            step(4'b0010, 1'b0, 1'b1);
            if (!toRdy_) pulses++;
        end
        step(4'b0010, 1'b0, 1'b0);
        if (!toRdy_) pulses++;
        for (int n = 0; n < 5; n++) begin
            step(4'b0010, 1'b1, 1'b1);
            if (!toRdy_) pulses++;
        end
        check("t5b pulses", pulses, 0);
        check("t5b busErr", busErr, 0);

        // Reset mid-grant and mid-count
        doReset();
        step(4'b0100, 1'b1, 1'b1);
        for (int n = 1; n <= 40; n++) step(4'b0100, 1'b0, 1'b1);
        check("t6 preErr", busErr, 1);
        doReset();
        step(4'b1111, 1'b1, 1'b1);
        check("t6 first", owner, 0);
        check("t6 vld", ownerVld, 1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
